// File: rtl/fpi2c_sched.sv
// fpi2c_sched: shares the i2cmaster command slot between host one-shot
// requests and a periodic four-entry scan table, with per-transaction timeout.
module fpi2c_sched #(
    parameter int unsigned TIMEOUT = 200000,
    parameter logic [31:0] IDWORD  = 32'h5343_1001
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [3:0]  armwaddr,
    input  logic [3:0]  armraddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        m_wrcmd,
    output logic [63:0] m_command,
    input  logic [63:0] m_status,
    input  logic        m_done,
    output logic        m_clear,
    output logic        irq
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] hcmd_q, hcmd_d;
    logic [63:0] hres_q, hres_d;
    logic [63:0] mcmd_q, mcmd_d;
    logic [63:0] tbl_q [4];
    logic [63:0] tbl_d [4];
    logic [63:0] res_q [4];
    logic [63:0] res_d [4];
    logic [23:0] period_q, period_d;
    logic [23:0] pcnt_q, pcnt_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [2:0]  nxt_q, nxt_d;
    logic [1:0]  index_q, index_d;
    logic [1:0]  entry_q, entry_d;
    logic        scanen_q, scanen_d;
    logic        hostie_q, hostie_d;
    logic        tmoie_q, tmoie_d;
    logic        hostpend_q, hostpend_d;
    logic        hostdone_q, hostdone_d;
    logic        tmo_q, tmo_d;
    logic        overrun_q, overrun_d;
    logic        roundpend_q, roundpend_d;
    logic        selhost_q, selhost_d;

    logic        done_ev;
    logic        tmo_ev;
    logic        found;
    logic [1:0]  pick;
    logic        hp_set;
    logic        round_clr;
    logic [23:0] per_m1;
    logic [63:0] fin_res;
    logic [31:0] ctrl;

    assign done_ev = (state_q == S_WAIT) && m_done;
    assign tmo_ev  = (state_q == S_WAIT) && !m_done && (tcnt_q <= 32'd1);
    assign fin_res = done_ev ? m_status : 64'hFFFF_FFFF_FFFF_FFFF;
    assign per_m1  = (period_q == 24'd0) ? 24'd0 : period_q - 24'd1;

    assign m_wrcmd   = (state_q == S_ISSUE);
    assign m_clear   = tmo_ev;
    assign m_command = mcmd_q;
    assign irq       = (hostdone_q & hostie_q) | (tmo_q & tmoie_q);

    assign ctrl = {14'd0, entry_q, 1'b0, (state_q != S_IDLE),
                   tmoie_q, hostie_q, overrun_q, tmo_q, hostdone_q,
                   hostpend_q, mask_q, 3'd0, scanen_q};

    // lowest enabled entry not yet issued in the current round
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) >= nxt_q)) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end

    always_comb begin
        case (armraddr)
            4'd0:    armrdata = IDWORD;
            4'd1:    armrdata = hcmd_q[31:0];
            4'd2:    armrdata = hcmd_q[63:32];
            4'd3:    armrdata = hres_q[31:0];
            4'd4:    armrdata = hres_q[63:32];
            4'd5:    armrdata = ctrl;
            4'd6:    armrdata = {8'd0, period_q};
            4'd7:    armrdata = {30'd0, index_q};
            4'd8:    armrdata = tbl_q[index_q][31:0];
            4'd9:    armrdata = tbl_q[index_q][63:32];
            4'd10:   armrdata = res_q[index_q][31:0];
            4'd11:   armrdata = res_q[index_q][63:32];
            default: armrdata = 32'hDEAD_BEEF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hcmd_d      = hcmd_q;
        hres_d      = hres_q;
        mcmd_d      = mcmd_q;
        tbl_d       = tbl_q;
        res_d       = res_q;
        period_d    = period_q;
        pcnt_d      = pcnt_q;
        tcnt_d      = tcnt_q;
        mask_d      = mask_q;
        nxt_d       = nxt_q;
        index_d     = index_q;
        entry_d     = entry_q;
        scanen_d    = scanen_q;
        hostie_d    = hostie_q;
        tmoie_d     = tmoie_q;
        hostpend_d  = hostpend_q;
        hostdone_d  = hostdone_q;
        tmo_d       = tmo_q;
        overrun_d   = overrun_q;
        roundpend_d = roundpend_q;
        selhost_d   = selhost_q;
        hp_set      = 1'b0;
        round_clr   = 1'b0;

        // W1C clears come first so a same-cycle hardware set wins
        if (armwrite) begin
            case (armwaddr)
                4'd1: hcmd_d[31:0] = armwdata;
                4'd2: begin
                    hcmd_d[63:32] = armwdata;
                    hp_set        = 1'b1;
                end
                4'd5: begin
                    scanen_d = armwdata[0];
                    mask_d   = armwdata[7:4];
                    hostie_d = armwdata[12];
                    tmoie_d  = armwdata[13];
                    if (armwdata[9])  hostdone_d = 1'b0;
                    if (armwdata[10]) tmo_d      = 1'b0;
                    if (armwdata[11]) overrun_d  = 1'b0;
                end
                4'd6: period_d = armwdata[23:0];
                4'd7: index_d  = armwdata[1:0];
                4'd8: tbl_d[index_q][31:0]  = armwdata;
                4'd9: tbl_d[index_q][63:32] = armwdata;
                default: ;
            endcase
        end
        if (hp_set) hostpend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (hostpend_q) begin
                    selhost_d = 1'b1;
                    mcmd_d    = hcmd_q;
                    state_d   = S_ISSUE;
                end else if (roundpend_q && found) begin
                    selhost_d = 1'b0;
                    entry_d   = pick;
                    nxt_d     = {1'b0, pick} + 3'd1;
                    mcmd_d    = tbl_q[pick];
                    state_d   = S_ISSUE;
                end else if (roundpend_q) begin
                    round_clr   = 1'b1;
                    roundpend_d = 1'b0;
                    nxt_d       = 3'd0;
                end
            end
            S_ISSUE: begin
                tcnt_d  = 32'(TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tcnt_d = tcnt_q - 32'd1;
                if (done_ev || tmo_ev) begin
                    if (selhost_q) begin
                        hres_d     = fin_res;
                        hostdone_d = 1'b1;
                        hostpend_d = hp_set;
                    end else begin
                        res_d[entry_q] = fin_res;
                    end
                    if (tmo_ev) tmo_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!scanen_q) begin
            pcnt_d      = per_m1;
            roundpend_d = 1'b0;
            nxt_d       = 3'd0;
        end else if (pcnt_q == 24'd0) begin
            pcnt_d = per_m1;
            if (roundpend_q && !round_clr) overrun_d = 1'b1;
            roundpend_d = 1'b1;
        end else begin
            pcnt_d = pcnt_q - 24'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            hcmd_q      <= '0;
            hres_q      <= '0;
            mcmd_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                tbl_q[i] <= '0;
                res_q[i] <= '0;
            end
            period_q    <= '0;
            pcnt_q      <= '0;
            tcnt_q      <= '0;
            mask_q      <= '0;
            nxt_q       <= '0;
            index_q     <= '0;
            entry_q     <= '0;
            scanen_q    <= 1'b0;
            hostie_q    <= 1'b0;
            tmoie_q     <= 1'b0;
            hostpend_q  <= 1'b0;
            hostdone_q  <= 1'b0;
            tmo_q       <= 1'b0;
            overrun_q   <= 1'b0;
            roundpend_q <= 1'b0;
            selhost_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcmd_q      <= hcmd_d;
            hres_q      <= hres_d;
            mcmd_q      <= mcmd_d;
            tbl_q       <= tbl_d;
            res_q       <= res_d;
            period_q    <= period_d;
            pcnt_q      <= pcnt_d;
            tcnt_q      <= tcnt_d;
            mask_q      <= mask_d;
            nxt_q       <= nxt_d;
            index_q     <= index_d;
            entry_q     <= entry_d;
            scanen_q    <= scanen_d;
            hostie_q    <= hostie_d;
            tmoie_q     <= tmoie_d;
            hostpend_q  <= hostpend_d;
            hostdone_q  <= hostdone_d;
            tmo_q       <= tmo_d;
            overrun_q   <= overrun_d;
            roundpend_q <= roundpend_d;
            selhost_q   <= selhost_d;
        end
    end
endmodule

// File: tb/tb_fpi2c_sched.sv
// tb_fpi2c_sched: randomized scenarios against a transaction-level model
// of the scheduler (issue order, results, timeout and overrun rules).
module tb_fpi2c_sched;
    localparam int TMO = 50;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        armwrite = 1'b0;
    logic [3:0]  armwaddr = '0;
    logic [3:0]  armraddr = '0;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic        m_wrcmd;
    logic [63:0] m_command;
    logic [63:0] m_status;
    logic        m_done;
    logic        m_clear;
    logic        irq;

    fpi2c_sched #(.TIMEOUT(TMO)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armwaddr(armwaddr),
        .armraddr(armraddr), .armwdata(armwdata),
        .armrdata(armrdata), .m_wrcmd(m_wrcmd),
        .m_command(m_command), .m_status(m_status),
        .m_done(m_done), .m_clear(m_clear), .irq(irq)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // observed transactions, recorded away from the active edge
    logic [63:0] issued[$];
    int          issued_cyc[$];
    int          clr_cyc[$];
    always @(negedge CLOCK) begin
        if (m_wrcmd === 1'b1) begin
            issued.push_back(m_command);
            issued_cyc.push_back(cyc);
        end
        if (m_clear === 1'b1) clr_cyc.push_back(cyc);
    end

    // i2cmaster model: answers each command with cmd ^ stat_xor
    logic        resp_en = 1'b1;
    logic        drop_en = 1'b0;
    logic        stray_req = 1'b0;
    logic [63:0] drop_cmd = '0;
    logic [63:0] stat_xor = '0;
    logic [63:0] rc;
    int          dly_lo = 5;
    int          dly_hi = 20;
    initial begin
        m_done = 1'b0;
        m_status = '0;
        forever begin
            @(negedge CLOCK);
            if (stray_req) begin
                m_status = 64'h1357_9BDF_2468_ACE0;
                m_done = 1'b1;
                @(negedge CLOCK);
                m_done = 1'b0;
                stray_req = 1'b0;
            end else if (m_wrcmd === 1'b1 && resp_en &&
                         !(drop_en && m_command == drop_cmd)) begin
                rc = m_command;
                repeat ($urandom_range(dly_hi, dly_lo)) @(negedge CLOCK);
                m_status = rc ^ stat_xor;
                m_done = 1'b1;
                @(negedge CLOCK);
                m_done = 1'b0;
            end
        end
    end

    logic [63:0] tb_tbl [4];

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLOCK);
        last_wr_cyc = cyc;
        armwrite = 1'b1;
        armwaddr = a;
        armwdata = d;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
        @(negedge CLOCK);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic wait_issue(input int n, input int budget, input string nm);
        int k = 0;
        while (issued.size() < n && k < budget) begin
            @(negedge CLOCK);
            k++;
        end
        checks++;
        if (issued.size() < n) begin
            failures++;
            $display("FAIL %s: issued %0d, required %0d", nm, issued.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        wait_cycles(3);
        checks++;
        if ({m_wrcmd, m_clear, irq} !== 3'b000 || m_command !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: wrcmd=%b clear=%b irq=%b cmd=%h, required 0",
                     m_wrcmd, m_clear, irq, m_command);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        rd_reg(0, d);
        checks++;
        if (d !== 32'h5343_1001) begin
            failures++;
            $display("FAIL reset_id: got %h, required 53431001", d);
        end
        rd_reg(5, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h, required 0", d);
        end
        rd_reg(12, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL reset_r12: got %h, required deadbeef", d);
        end
        wr_reg(15, 32'h1);
        rd_reg(15, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL reset_r15: got %h, required deadbeef", d);
        end
    endtask

    task automatic test_host();
        logic [31:0] d, e;
        logic [63:0] hc;
        int wc;
        stat_xor = 64'h0000_ABCD_0000_1234 ^ 64'h55;
        dly_lo = 10;
        dly_hi = 10;
        wr_reg(5, 32'h1000);
        issued.delete();
        issued_cyc.delete();
        wr_reg(1, 32'h1234);
        wr_reg(2, 32'hABCD);
        wc = last_wr_cyc;
        wait_issue(1, 10, "host_issue");
        wait_cycles(20);
        checks++;
        if (issued.size() != 1 || issued[0] !== 64'h0000_ABCD_0000_1234) begin
            failures++;
            $display("FAIL host_cmd: count %0d cmd %h, required 1 x 0000abcd00001234",
                     issued.size(), issued.size() > 0 ? issued[0] : 64'd0);
        end
        checks++;
        if (issued_cyc.size() < 1 || issued_cyc[0] - wc != 2) begin
            failures++;
            $display("FAIL host_latency: got %0d, required 2",
                     issued_cyc.size() > 0 ? issued_cyc[0] - wc : -1);
        end
        rd_reg(3, d);
        rd_reg(4, e);
        checks++;
        if ({e, d} !== 64'h55) begin
            failures++;
            $display("FAIL host_result: got %h%h, required 55", e, d);
        end
        rd_reg(5, d);
        checks++;
        if (d[9:8] !== 2'b10 || irq !== 1'b1) begin
            failures++;
            $display("FAIL host_flags: done/pend=%b irq=%b, required 10/1", d[9:8], irq);
        end
        wr_reg(5, 32'h1200);
        rd_reg(5, d);
        checks++;
        if (d[9] !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL host_w1c: hostdone=%b irq=%b, required 0/0", d[9], irq);
        end
        for (int r = 0; r < 3; r++) begin
            hc = {$urandom, $urandom};
            stat_xor = {$urandom, $urandom};
            dly_lo = 1;
            dly_hi = 30;
            issued.delete();
            wr_reg(1, hc[31:0]);
            wr_reg(2, hc[63:32]);
            wait_issue(1, 10, "host_rand_issue");
            wait_cycles(40);
            rd_reg(3, d);
            rd_reg(4, e);
            checks++;
            if (issued.size() != 1 || issued[0] !== hc || {e, d} !== (hc ^ stat_xor)) begin
                failures++;
                $display("FAIL host_rand: count %0d result %h%h, required 1 / %h",
                         issued.size(), e, d, hc ^ stat_xor);
            end
        end
        wr_reg(5, 32'h200);
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) begin
            tb_tbl[i] = {$urandom, $urandom};
            if (i > 0 && tb_tbl[i] == tb_tbl[0]) tb_tbl[i] = ~tb_tbl[0];
            wr_reg(7, 32'(i));
            wr_reg(8, tb_tbl[i][31:0]);
            wr_reg(9, tb_tbl[i][63:32]);
        end
    endtask

    task automatic test_scan();
        logic [31:0] d, e;
        logic [63:0] exp;
        load_table();
        wr_reg(7, 32'd2);
        rd_reg(9, d);
        checks++;
        if (d !== tb_tbl[2][63:32]) begin
            failures++;
            $display("FAIL tbl_readback: got %h, required %h", d, tb_tbl[2][63:32]);
        end
        stat_xor = {$urandom, $urandom};
        dly_lo = 5;
        dly_hi = 20;
        wr_reg(6, 32'd1000);
        issued.delete();
        issued_cyc.delete();
        wr_reg(5, 32'h51);
        wait_cycles(2100);
        wr_reg(5, 32'h0);
        wait_cycles(50);
        checks++;
        if (issued.size() != 4 || issued[0] !== tb_tbl[0] || issued[1] !== tb_tbl[2] ||
            issued[2] !== tb_tbl[0] || issued[3] !== tb_tbl[2]) begin
            failures++;
            $display("FAIL scan_order: count %0d, required 4 as e0,e2,e0,e2", issued.size());
        end
        checks++;
        if (issued_cyc.size() < 3 || issued_cyc[2] - issued_cyc[0] != 1000) begin
            failures++;
            $display("FAIL scan_period: got %0d, required 1000",
                     issued_cyc.size() >= 3 ? issued_cyc[2] - issued_cyc[0] : -1);
        end
        for (int i = 0; i < 4; i++) begin
            exp = (i == 0 || i == 2) ? (tb_tbl[i] ^ stat_xor) : 64'd0;
            wr_reg(7, 32'(i));
            rd_reg(10, d);
            rd_reg(11, e);
            checks++;
            if ({e, d} !== exp) begin
                failures++;
                $display("FAIL scan_result%0d: got %h%h, required %h", i, e, d, exp);
            end
        end
        rd_reg(5, d);
        checks++;
        if (d[11] !== 1'b0 || d[14] !== 1'b0) begin
            failures++;
            $display("FAIL scan_flags: overrun=%b busy=%b, required 0/0", d[11], d[14]);
        end
    endtask

    task automatic test_host_during();
        logic [31:0] d, e;
        logic [63:0] hc;
        hc = {$urandom, $urandom};
        dly_lo = 20;
        dly_hi = 20;
        wr_reg(6, 32'd200);
        issued.delete();
        issued_cyc.delete();
        wr_reg(5, 32'h51);
        wait_issue(1, 400, "during_first");
        wr_reg(1, hc[31:0]);
        wr_reg(2, hc[63:32]);
        wait_issue(3, 200, "during_three");
        wr_reg(5, 32'h0);
        wait_cycles(60);
        checks++;
        if (issued.size() < 3 || issued[0] !== tb_tbl[0] || issued[1] !== hc ||
            issued[2] !== tb_tbl[2]) begin
            failures++;
            $display("FAIL host_during_order: count %0d, required e0,host,e2", issued.size());
        end
        rd_reg(3, d);
        rd_reg(4, e);
        checks++;
        if ({e, d} !== (hc ^ stat_xor)) begin
            failures++;
            $display("FAIL host_during_result: got %h%h, required %h", e, d, hc ^ stat_xor);
        end
        wr_reg(5, 32'h200);
    endtask

    task automatic test_timeout();
        logic [31:0] d, e;
        drop_en = 1'b1;
        drop_cmd = tb_tbl[0];
        dly_lo = 5;
        dly_hi = 15;
        wr_reg(6, 32'd300);
        issued.delete();
        issued_cyc.delete();
        clr_cyc.delete();
        wr_reg(5, 32'h2051);
        wait_issue(2, 700, "tmo_next");
        wait_cycles(40);
        checks++;
        if (clr_cyc.size() != 1 || issued_cyc.size() < 1 || clr_cyc[0] - issued_cyc[0] != TMO) begin
            failures++;
            $display("FAIL tmo_clear: pulses %0d delay %0d, required 1 / %0d", clr_cyc.size(),
                     (clr_cyc.size() > 0 && issued_cyc.size() > 0) ? clr_cyc[0] - issued_cyc[0] : -1,
                     TMO);
        end
        checks++;
        if (issued.size() < 2 || issued[1] !== tb_tbl[2]) begin
            failures++;
            $display("FAIL tmo_next_entry: count %0d, required e2 after e0", issued.size());
        end
        rd_reg(5, d);
        checks++;
        if (d[10] !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL tmo_flag: tmo=%b irq=%b, required 1/1", d[10], irq);
        end
        wr_reg(7, 32'd0);
        rd_reg(10, d);
        rd_reg(11, e);
        checks++;
        if ({e, d} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL tmo_result: got %h%h, required all ones", e, d);
        end
        wr_reg(7, 32'd2);
        rd_reg(10, d);
        rd_reg(11, e);
        checks++;
        if ({e, d} !== (tb_tbl[2] ^ stat_xor)) begin
            failures++;
            $display("FAIL tmo_result2: got %h%h, required %h", e, d, tb_tbl[2] ^ stat_xor);
        end
        wr_reg(5, 32'h2400);
        wait_cycles(80);
        rd_reg(5, d);
        checks++;
        if (d[10] !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL tmo_w1c: tmo=%b irq=%b, required 0/0", d[10], irq);
        end
        wr_reg(5, 32'h0);
        drop_en = 1'b0;
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        int bad = 0;
        int n;
        dly_lo = 30;
        dly_hi = 30;
        wr_reg(6, 32'd20);
        issued.delete();
        issued_cyc.delete();
        wr_reg(5, 32'h51);
        wait_cycles(400);
        wr_reg(5, 32'h0);
        wait_cycles(60);
        rd_reg(5, d);
        checks++;
        if (d[11] !== 1'b1 || d[14] !== 1'b0) begin
            failures++;
            $display("FAIL overrun_flag: overrun=%b busy=%b, required 1/0", d[11], d[14]);
        end
        foreach (issued[i]) if (issued[i] !== tb_tbl[(i % 2) * 2]) bad++;
        checks++;
        if (bad != 0 || issued.size() < 8) begin
            failures++;
            $display("FAIL overrun_order: misordered %0d of %0d, required 0 of >=8",
                     bad, issued.size());
        end
        n = issued.size();
        wait_cycles(100);
        checks++;
        if (issued.size() != n) begin
            failures++;
            $display("FAIL scan_stop: got %0d issues, required %0d", issued.size(), n);
        end
        wr_reg(5, 32'h800);
        rd_reg(5, d);
        checks++;
        if (d[11] !== 1'b0) begin
            failures++;
            $display("FAIL overrun_w1c: got %b, required 0", d[11]);
        end
    endtask

    task automatic test_mask0_stray();
        logic [31:0] d0, d1, d;
        int k = 0;
        wr_reg(6, 32'd5);
        issued.delete();
        wr_reg(5, 32'h1);
        wait_cycles(100);
        rd_reg(5, d);
        wr_reg(5, 32'h0);
        checks++;
        if (issued.size() != 0 || d[11] !== 1'b0 || d[14] !== 1'b0) begin
            failures++;
            $display("FAIL mask0: issues %0d overrun %b busy %b, required 0/0/0",
                     issued.size(), d[11], d[14]);
        end
        rd_reg(3, d0);
        stray_req = 1'b1;
        while (stray_req && k < 20) begin
            @(negedge CLOCK);
            k++;
        end
        wait_cycles(3);
        rd_reg(3, d1);
        rd_reg(5, d);
        checks++;
        if (d1 !== d0 || d[9] !== 1'b0 || d[14] !== 1'b0) begin
            failures++;
            $display("FAIL idle_done: res %h hostdone %b, required %h / 0", d1, d[9], d0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int k = 0;
        resp_en = 1'b0;
        wr_reg(1, $urandom);
        wr_reg(2, $urandom);
        while (m_wrcmd !== 1'b1 && k < 10) begin
            @(negedge CLOCK);
            k++;
        end
        checks++;
        if (m_wrcmd !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_issue: wrcmd=%b, required 1", m_wrcmd);
        end
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (m_wrcmd !== 1'b0 || m_clear !== 1'b0 || m_command !== 64'd0) begin
            failures++;
            $display("FAIL rst_mid_async: wrcmd=%b clear=%b cmd=%h, required 0",
                     m_wrcmd, m_clear, m_command);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        rd_reg(5, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_ctrl: got %h, required 0", d);
        end
        resp_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_host();
        test_scan();
        test_host_during();
        test_timeout();
        test_overrun();
        test_mask0_stray();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
